// File: rtl/pipe_generator.sv
// ---------------------------------------------------------------------------
// pipe_generator
//
// Pipe-column source for the scrolling LED playfield. Once per scroll step it
// emits one display column. The column is either a pipe with a pseudo-random
// gap or an empty spacer column. The scroll step period shortens as pipes are
// issued (difficulty levels). Dropping enable pauses the block.
//
// Ports
//   clk       in   1             system clock
//   rst       in   1             synchronous, active-high reset (beats enable)
//   enable    in   1             1 = run, 0 = pause (all state holds)
//   step      out  1             one-cycle pulse: a new column is valid
//   column    out  ROWS          bit i = row i; 1 = pipe lit, 0 = gap/empty
//   pipe_new  out  1             pulses with step when column is a pipe
//   gap_top   out  $clog2(ROWS)  lowest gap row of the most recent pipe
//   level     out  4             difficulty level, saturates at 15
//
// Handshake: step is a plain one-cycle strobe with no back-pressure. column,
// pipe_new and gap_top are valid in the cycle where step is high. column,
// gap_top and level hold between strobes.
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module pipe_generator #(
  parameter int          ROWS            = 16,
  parameter int          GAP             = 4,
  parameter int          START_PERIOD    = 218,
  parameter int          MIN_PERIOD      = 40,
  parameter int          PERIOD_STEP     = 16,
  parameter int          SPACING         = 4,
  parameter int          PIPES_PER_LEVEL = 8,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    step,
  output logic [ROWS-1:0]         column,
  output logic                    pipe_new,
  output logic [$clog2(ROWS)-1:0] gap_top,
  output logic [3:0]              level
);

  localparam int CW = $clog2(START_PERIOD + 1);
  localparam int SW = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int PW = $clog2(PIPES_PER_LEVEL + 1);
  localparam int GW = $clog2(ROWS);
  // Number of legal gap positions: the gap must fit entirely inside the column.
  localparam int GAP_POS = ROWS - GAP + 1;
  // An all-zero LFSR would lock up, so a zero seed is replaced with 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // State
  logic [CW-1:0] cnt;       // clocks elapsed in the current step window
  logic [SW-1:0] slot;      // position within the pipe/spacer pattern
  logic [PW-1:0] pipe_cnt;  // pipes issued since the last level increment
  logic [15:0]   lfsr;

  // Combinational helpers
  logic [31:0]     period_dec;
  logic [CW-1:0]   period;
  logic            at_step;
  logic            is_pipe;
  logic            lfsr_fb;
  logic [15:0]     lfsr_next;
  logic [GW-1:0]   gap_g;
  logic [ROWS-1:0] pipe_col;
  logic [PW-1:0]   pipe_cnt_inc;
  logic            level_up;
  logic [SW-1:0]   slot_next;

  // The period is clamped before the subtraction. This keeps
  // START_PERIOD - level*PERIOD_STEP from underflowing at high levels.
  always_comb begin
    period_dec = 32'(level) * 32'(PERIOD_STEP);
    if (period_dec >= 32'(START_PERIOD - MIN_PERIOD)) begin
      period = CW'(MIN_PERIOD);
    end else begin
      period = CW'(32'(START_PERIOD) - period_dec);
    end
  end

  // A step fires on the edge where the window count reaches period-1.
  // When period is 1, every enabled cycle is a step.
  assign at_step = (cnt == (period - CW'(1)));
  assign is_pipe = (slot == '0);

  // Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1. It shifts left and
  // feeds back into bit 0.
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_next = {lfsr[14:0], lfsr_fb};

  // The gap position comes from the current LFSR value. The LFSR advances
  // only after that value has been used.
  assign gap_g = GW'(32'(lfsr[7:0]) % 32'(GAP_POS));

  always_comb begin
    pipe_col = '1;
    for (int i = 0; i < ROWS; i++) begin
      if ((i >= int'(gap_g)) && (i < int'(gap_g) + GAP)) begin
        pipe_col[i] = 1'b0;
      end
    end
  end

  assign pipe_cnt_inc = pipe_cnt + PW'(1);
  assign level_up     = (pipe_cnt_inc == PW'(PIPES_PER_LEVEL));
  assign slot_next    = (slot == SW'(SPACING - 1)) ? '0 : slot + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      slot     <= '0;
      pipe_cnt <= '0;
      level    <= '0;
      lfsr     <= SEED_EFF;
      column   <= '0;
      step     <= 1'b0;
      pipe_new <= 1'b0;
      gap_top  <= '0;
    end else if (enable) begin
      step     <= 1'b0;
      pipe_new <= 1'b0;
      if (at_step) begin
        cnt  <= '0;
        step <= 1'b1;
        slot <= slot_next;
        if (is_pipe) begin
          column   <= pipe_col;
          gap_top  <= gap_g;
          pipe_new <= 1'b1;
          lfsr     <= lfsr_next;
          if (level_up) begin
            pipe_cnt <= '0;
            // The new level's period takes effect for the window that
            // begins at this step.
            if (level != 4'hF) begin
              level <= level + 4'd1;
            end
          end else begin
            pipe_cnt <= pipe_cnt_inc;
          end
        end else begin
          column <= '0;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      // Pause: every state register holds, and the strobes drop.
      step     <= 1'b0;
      pipe_new <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_generator.sv
// ---------------------------------------------------------------------------
// tb_pipe_generator
//
// Bench for pipe_generator, configured with its small test parameter set.
// A behavioural model tracks these quantities as plain integers:
//   - enabled clocks since the last step
//   - total steps
//   - total pipes
//   - the LFSR value
// From them it predicts every registered output. A compare process checks
// the DUT against the model on each falling edge. Directed sections pin the
// model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_pipe_generator;

  localparam int          P_ROWS  = 16;
  localparam int          P_GAP   = 4;
  localparam int          P_START = 3;
  localparam int          P_MIN   = 1;
  localparam int          P_STEP  = 1;
  localparam int          P_SPACE = 2;
  localparam int          P_PPL   = 2;
  localparam logic [15:0] P_SEED  = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic              step;
  logic [P_ROWS-1:0] column;
  logic              pipe_new;
  logic [3:0]        gap_top;
  logic [3:0]        level;

  pipe_generator #(
    .ROWS(P_ROWS), .GAP(P_GAP), .START_PERIOD(P_START), .MIN_PERIOD(P_MIN),
    .PERIOD_STEP(P_STEP), .SPACING(P_SPACE), .PIPES_PER_LEVEL(P_PPL), .SEED(P_SEED)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .step(step), .column(column),
    .pipe_new(pipe_new), .gap_top(gap_top), .level(level)
  );

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int model_period(input int lv);
    if (lv * P_STEP >= P_START - P_MIN) return P_MIN;
    return P_START - lv * P_STEP;
  endfunction

  function automatic logic [15:0] model_lfsr_adv(input logic [15:0] v);
    // Taps 16,14,13,11 -> bits 15,13,12,10; shift left, feedback into bit 0.
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  int          m_elapsed = 0;
  int          m_steps   = 0;
  int          m_pipes   = 0;
  logic [15:0] m_lfsr    = P_SEED;
  logic        e_step    = 1'b0;
  logic        e_new     = 1'b0;
  logic [15:0] e_col     = '0;
  logic [3:0]  e_gap     = '0;
  logic [3:0]  e_level   = '0;
  logic [3:0]  exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_elapsed = 0; m_steps = 0; m_pipes = 0; m_lfsr = P_SEED;
      e_step = 0; e_new = 0; e_col = '0; e_gap = '0; e_level = '0;
      exp_q.delete();
    end else if (enable) begin
      e_step = 0;
      e_new  = 0;
      m_elapsed++;
      if (m_elapsed == model_period(int'(e_level))) begin
        m_elapsed = 0;
        e_step    = 1;
        if (m_steps % P_SPACE == 0) begin
          e_gap = 4'(int'(m_lfsr[7:0]) % (P_ROWS - P_GAP + 1));
          e_col = ~(16'h000F << e_gap);
          e_new = 1;
          exp_q.push_back(e_gap);
          m_lfsr = model_lfsr_adv(m_lfsr);
          m_pipes++;
          e_level = (m_pipes / P_PPL > 15) ? 4'd15 : 4'(m_pipes / P_PPL);
        end else begin
          e_col = '0;
        end
        m_steps++;
      end
    end else begin
      e_step = 0;
      e_new  = 0;
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  logic [15:0] inv_col;
  logic [15:0] gap_mask;
  logic [3:0]  q_gap;
  always @(negedge clk) begin
    chk("step",     32'(step),     32'(e_step));
    chk("pipe_new", 32'(pipe_new), 32'(e_new));
    chk("column",   32'(column),   32'(e_col));
    chk("gap_top",  32'(gap_top),  32'(e_gap));
    chk("level",    32'(level),    32'(e_level));
    if (step && pipe_new) begin
      inv_col  = ~column;
      gap_mask = 16'h000F << gap_top;
      chk("gap_shape", 32'(inv_col), 32'(gap_mask));
      chk("gap_range", 32'(gap_top <= 4'd12), 32'd1);
      if (exp_q.size() == 0) begin
        chk("queue_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        q_gap = exp_q.pop_front();
        chk("queue_gap", 32'(gap_top), 32'(q_gap));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Counts falling edges until step is seen. The wait is bounded.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 50);
    if (!step) chk("step_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    // Test 1: reset, then first step after 3 enabled clocks.
    rst = 1; enable = 0;
    repeat (2) @(negedge clk);
    chk("reset_column", 32'(column), 32'd0);
    chk("reset_step",   32'(step),   32'd0);
    chk("reset_level",  32'(level),  32'd0);
    rst = 0; enable = 1;
    wait_step(n);
    chk("first_latency",  32'(n),        32'd3);
    chk("first_column",   32'(column),   32'hFF0F);
    chk("first_gap",      32'(gap_top),  32'd4);
    chk("first_pipe_new", 32'(pipe_new), 32'd1);
    chk("first_level",    32'(level),    32'd0);

    // Test 2: spacer, then second pipe (LFSR 0x59C3 -> 0xC3 % 13 = 0).
    wait_step(n);
    chk("spacer_latency",  32'(n),        32'd3);
    chk("spacer_column",   32'(column),   32'd0);
    chk("spacer_pipe_new", 32'(pipe_new), 32'd0);
    chk("spacer_gap_hold", 32'(gap_top),  32'd4);
    wait_step(n);
    chk("pipe2_latency", 32'(n),      32'd3);
    chk("pipe2_column",  32'(column), 32'hFFF0);
    chk("pipe2_gap",     32'(gap_top), 32'd0);
    chk("pipe2_level",   32'(level),  32'd1);

    // Test 3: level 1 gives period 2, for pipes 3 and 4.
    for (int k = 0; k < 4; k++) begin
      wait_step(n);
      chk("lvl1_latency", 32'(n), 32'd2);
    end
    chk("lvl2_level", 32'(level), 32'd2);
    wait_step(n);
    chk("lvl2_latency", 32'(n), 32'd1);

    // Test 5: reset at level 2.
    rst = 1;
    @(negedge clk);
    chk("midrst_level",  32'(level),   32'd0);
    chk("midrst_column", 32'(column),  32'd0);
    chk("midrst_step",   32'(step),    32'd0);
    chk("midrst_gap",    32'(gap_top), 32'd0);
    @(negedge clk);
    rst = 0; enable = 1;
    wait_step(n);
    chk("rerun_latency", 32'(n),       32'd3);
    chk("rerun_column",  32'(column),  32'hFF0F);
    chk("rerun_gap",     32'(gap_top), 32'd4);

    // Test 4: pause with cnt=1. Outputs hold and no step fires. After resume,
    // the window still totals 3 enabled clocks.
    @(negedge clk);
    enable = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("pause_step",   32'(step),    32'd0);
      chk("pause_column", 32'(column),  32'hFF0F);
      chk("pause_gap",    32'(gap_top), 32'd4);
    end
    enable = 1;
    wait_step(n);
    chk("resume_latency", 32'(n), 32'd2);

    // Test 6: long random run; level saturates at 15.
    run_random(2000);
    enable = 1;
    chk("enough_pipes", 32'(m_pipes >= 200), 32'd1);
    wait_step(n);
    chk("sat_level", 32'(level), 32'd15);
    wait_step(n);
    chk("clamp_latency", 32'(n), 32'd1);

    // Random mid-run resets; rst overrides enable.
    for (int k = 0; k < 6; k++) begin
      run_random($urandom_range(10, 150));
      rst = 1;
      enable = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      chk("rand_rst_level", 32'(level), 32'd0);
      rst = 0;
    end
    run_random(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
